// File: rtl/timer_host_ctrl.sv
// Host-side sequencer for a memory-mapped interval timer: programs period/control,
// stops the timer, services its interrupt and reads a coherent 32-bit counter snapshot.
module timer_host_ctrl #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_req,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              cfg_irq_en,
    input  logic              stop_req,
    input  logic              snap_req,
    output logic              busy,
    output logic              snap_valid,
    output logic [31:0]       snapshot,
    output logic [TICK_W-1:0] tick_count,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              timer_irq,
    output logic [3:0]        dbg_state
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] CFG_PL    = 4'd1;
    localparam logic [3:0] CFG_PH    = 4'd2;
    localparam logic [3:0] CFG_CTRL  = 4'd3;
    localparam logic [3:0] STOP_WR   = 4'd4;
    localparam logic [3:0] CLR_WR    = 4'd5;
    localparam logic [3:0] SNAP_WR   = 4'd6;
    localparam logic [3:0] SNAP_RL_A = 4'd7;
    localparam logic [3:0] SNAP_RL_D = 4'd8;
    localparam logic [3:0] SNAP_RH_A = 4'd9;
    localparam logic [3:0] SNAP_RH_D = 4'd10;

    logic [3:0]  state;
    logic [3:0]  state_nxt;
    logic [31:0] period_q;
    logic        continuous_q;
    logic        irq_en_q;
    logic        irq_mask;
    logic [15:0] snap_lo_q;

    // Requests are single-cycle pulses sampled only while IDLE (busy=0); a pulse
    // seen while busy=1 is discarded, never queued. timer_irq is a level.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (timer_irq && !irq_mask) state_nxt = CLR_WR;
                else if (stop_req)          state_nxt = STOP_WR;
                else if (cfg_req)           state_nxt = CFG_PL;
                else if (snap_req)          state_nxt = SNAP_WR;
            end
            CFG_PL:    state_nxt = CFG_PH;
            CFG_PH:    state_nxt = CFG_CTRL;
            SNAP_WR:   state_nxt = SNAP_RL_A;
            SNAP_RL_A: state_nxt = SNAP_RL_D;
            SNAP_RL_D: state_nxt = SNAP_RH_A;
            SNAP_RH_A: state_nxt = SNAP_RH_D;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            period_q     <= '0;
            continuous_q <= 1'b0;
            irq_en_q     <= 1'b0;
            irq_mask     <= 1'b0;
            snap_lo_q    <= '0;
            snap_valid   <= 1'b0;
            snapshot     <= '0;
            tick_count   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == CFG_PL) begin
                period_q     <= cfg_period;
                continuous_q <= cfg_continuous;
                irq_en_q     <= cfg_irq_en;
            end
            // The slave drops its irq level one cycle late; mask that stale cycle.
            irq_mask <= (state == CLR_WR);
            if (state == CLR_WR) tick_count <= tick_count + TICK_W'(1);
            if (state == SNAP_RL_D) snap_lo_q <= avm_readdata;
            snap_valid <= (state == SNAP_RH_D);
            if (state == SNAP_RH_D) snapshot <= {avm_readdata, snap_lo_q};
        end
    end

    // Bus is decoded from state alone, so reset idles it without waiting for a clock.
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = 3'd0;
        avm_writedata  = 16'h0000;
        case (state)
            CFG_PL: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd2; avm_writedata = period_q[15:0];
            end
            CFG_PH: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd3; avm_writedata = period_q[31:16];
            end
            CFG_CTRL: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd1; avm_writedata = {12'h000, 2'b01, continuous_q, irq_en_q};
            end
            STOP_WR: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd1; avm_writedata = 16'h0008;
            end
            CLR_WR: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd0;
            end
            SNAP_WR: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd4;
            end
            SNAP_RL_A: begin
                avm_chipselect = 1'b1; avm_address = 3'd4;
            end
            SNAP_RH_A: begin
                avm_chipselect = 1'b1; avm_address = 3'd5;
            end
            default: ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_timer_host_ctrl.sv
// Randomized scoreboard bench for timer_host_ctrl: expected bus cycles and snapshots
// are queued at issue time and checked by an independent negedge monitor.
module tb_timer_host_ctrl;

    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_req, cfg_continuous, cfg_irq_en, stop_req, snap_req, timer_irq;
    logic [31:0]   cfg_period;
    logic          busy, snap_valid;
    logic [31:0]   snapshot;
    logic [TW-1:0] tick_count;
    logic [2:0]    avm_address;
    logic          avm_chipselect, avm_write_n;
    logic [15:0]   avm_writedata, avm_readdata;
    logic [3:0]    dbg_state;

    logic [15:0]   slave_lo, slave_hi;
    logic [19:0]   exp_q[$];
    logic [31:0]   snap_q[$];
    int            tick_m;
    int            vectors = 0;
    int            miscompares = 0;

    timer_host_ctrl #(.TICK_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_req(cfg_req), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .cfg_irq_en(cfg_irq_en), .stop_req(stop_req),
        .snap_req(snap_req), .busy(busy), .snap_valid(snap_valid), .snapshot(snapshot),
        .tick_count(tick_count), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .timer_irq(timer_irq), .dbg_state(dbg_state)
    );

    // clock / timeout
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    // timer slave read port: registered data, valid the cycle after the address
    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n)
            avm_readdata <= (avm_address == 3'd4) ? slave_lo :
                            (avm_address == 3'd5) ? slave_hi : 16'hDEAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] ent(input logic wn, input logic [2:0] a, input logic [15:0] d);
        return {wn, a, d};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_chipselect) begin
                if (exp_q.size() == 0) check("bus_unexpected", {12'h0, avm_write_n, avm_address, avm_writedata}, 32'hFFFFFFFF);
                else check("bus_cycle", {12'h0, avm_write_n, avm_address, avm_writedata}, {12'h0, exp_q.pop_front()});
            end else begin
                check("bus_idle", {12'h0, avm_write_n, avm_address, avm_writedata}, {12'h0, 1'b1, 19'h0});
            end
            if (snap_valid) begin
                if (snap_q.size() == 0) check("snap_unexpected", snapshot, ~snapshot);
                else check("snapshot", snapshot, snap_q.pop_front());
            end
        end
    end

    // kind: 0 irq, 1 stop, 2 cfg, 3 snap. extra[b] also raises kind b+1 on the same cycle.
    task automatic issue(input int kind, input logic [2:0] extra, input int drop_at,
                         input logic [31:0] per, input logic c, input logic ie,
                         input logic [15:0] slo, input logic [15:0] shi);
        int n;
        @(negedge clk);
        case (kind)
            0: begin
                timer_irq = 1'b1; n = 1;
                exp_q.push_back(ent(1'b0, 3'd0, 16'h0000));
                tick_m = (tick_m + 1) % (1 << TW);
            end
            1: begin
                stop_req = 1'b1; n = 1;
                exp_q.push_back(ent(1'b0, 3'd1, 16'h0008));
            end
            2: begin
                cfg_req = 1'b1; n = 3;
                cfg_period = per; cfg_continuous = c; cfg_irq_en = ie;
                exp_q.push_back(ent(1'b0, 3'd2, per[15:0]));
                exp_q.push_back(ent(1'b0, 3'd3, per[31:16]));
                exp_q.push_back(ent(1'b0, 3'd1, {12'h000, 2'b01, c, ie}));
            end
            default: begin
                snap_req = 1'b1; n = 5;
                slave_lo = slo; slave_hi = shi;
                exp_q.push_back(ent(1'b0, 3'd4, 16'h0000));
                exp_q.push_back(ent(1'b1, 3'd4, 16'h0000));
                exp_q.push_back(ent(1'b1, 3'd5, 16'h0000));
                snap_q.push_back({shi, slo});
            end
        endcase
        if (extra[0]) stop_req = 1'b1;
        if (extra[1]) cfg_req  = 1'b1;
        if (extra[2]) snap_req = 1'b1;
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            cfg_req = 1'b0; stop_req = 1'b0; snap_req = 1'b0;
            // the slave keeps its irq level up through the cycle after the clear write
            if (kind == 0 && k == 3) timer_irq = 1'b0;
            check("busy", {31'h0, busy}, {31'h0, (k <= n)});
            if (kind == 0 && k == 2) check("tick_count", {28'h0, tick_count}, tick_m);
            if (kind == 3) check("snap_valid_timing", {31'h0, snap_valid}, {31'h0, (k == n + 1)});
            if (k == drop_at && k <= n) begin
                case ($urandom_range(0, 2))
                    0:       stop_req = 1'b1;
                    1:       cfg_req  = 1'b1;
                    default: snap_req = 1'b1;
                endcase
            end
        end
    endtask

    initial begin
        int init_tick;
        int kind;
        logic [2:0] mask;
        reset_n = 1'b0;
        {cfg_req, cfg_continuous, cfg_irq_en, stop_req, snap_req, timer_irq} = '0;
        cfg_period = '0; slave_lo = '0; slave_hi = '0; tick_m = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_snap_valid", {31'h0, snap_valid}, 0);
        check("rst_snapshot", snapshot, 0);
        check("rst_tick", {28'h0, tick_count}, 0);
        check("rst_state", {28'h0, dbg_state}, 0);
        check("rst_bus", {11'h0, avm_chipselect, avm_write_n, avm_address, avm_writedata}, {11'h0, 1'b0, 1'b1, 19'h0});
        reset_n = 1'b1;
        @(negedge clk);

        // reset during the high-half read address cycle of a snapshot
        snap_req = 1'b1; slave_lo = 16'h5555; slave_hi = 16'h6666;
        exp_q.push_back(ent(1'b0, 3'd4, 16'h0000));
        exp_q.push_back(ent(1'b1, 3'd4, 16'h0000));
        @(negedge clk);
        snap_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_bus", {11'h0, avm_chipselect, avm_write_n, avm_address, avm_writedata}, {11'h0, 1'b0, 1'b1, 19'h0});
        check("rst_mid_busy", {31'h0, busy}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_snapshot", snapshot, 0);
        check("rst_mid_snap_valid", {31'h0, snap_valid}, 0);
        check("rst_mid_queue", exp_q.size(), 0);
        issue(3, 3'b000, 0, 32'h0, 1'b0, 1'b0, 16'h0F0F, 16'hF0F0);

        // directed: program, irq service, snapshot, simultaneous requests
        issue(2, 3'b000, 0, 32'h0001_86A0, 1'b1, 1'b1, 16'h0, 16'h0);
        issue(0, 3'b000, 0, 32'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        issue(3, 3'b000, 0, 32'h0, 1'b0, 1'b0, 16'h1234, 16'hABCD);
        issue(0, 3'b011, 0, 32'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        issue(1, 3'b110, 0, 32'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        issue(2, 3'b100, 0, 32'hFFFF_0000, 1'b0, 1'b1, 16'h0, 16'h0);

        // randomized mix with same-cycle lower-priority requests and drops while busy
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 3);
            mask = (kind == 0) ? 3'b111 : (kind == 1) ? 3'b110 : (kind == 2) ? 3'b100 : 3'b000;
            issue(kind, 3'($urandom_range(0, 7)) & mask, $urandom_range(0, 5), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // counter wrap: 16 services on a 4-bit counter return to the start value
        repeat (3) issue(0, 3'b000, 0, 32'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        init_tick = tick_m;
        repeat (16) issue(0, 3'b000, 0, 32'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        check("tick_wrap", {28'h0, tick_count}, init_tick);

        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("snap_q_drained", snap_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
